// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types and constants for the multiplexed 7-segment scan driver.
//   - seg7_state_e : scan FSM states (blanking, driving, select fault)
//   - SEG_OFF      : all segments dark
//   - SEG_TABLE    : hex nibble -> {g,f,e,d,c,b,a}, active-high, indexed by nibble value
package seg7_pkg;

    typedef enum logic [1:0] {
        ST_BLANK = 2'd0,
        ST_DRIVE = 2'd1,
        ST_FAULT = 2'd2
    } seg7_state_e;

    localparam logic [6:0] SEG_OFF = 7'h00;

    // Packed so that SEG_TABLE[n] is the pattern for hex digit n; the
    // concatenation therefore lists F first and 0 last.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39,   // F E d C
        7'h7C, 7'h77, 7'h6F, 7'h7F,   // b A 9 8
        7'h07, 7'h7D, 7'h6D, 7'h66,   // 7 6 5 4
        7'h4F, 7'h5B, 7'h06, 7'h3F    // 3 2 1 0
    };

endpackage

// File: rtl/seg7_hex2seg7.sv
// hex2seg7: combinational hex nibble to 7-segment decoder.
// Ports:
//   nibble_i  in  4  hex digit value 0..F
//   seg_o     out 7  segments {g,f,e,d,c,b,a}, active-high
module hex2seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG_TABLE[nibble_i];

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: drives a multiplexed WIDTH-digit 7-segment display from the
// rotating one-hot word of a ring counter. Every select change is followed by
// BLANK_CYC cycles of all-off to avoid ghosting; a non-one-hot select forces the
// FAULT state. All outputs are registered.
// Ports:
//   clk        in   1        clock, rising edge
//   rst        in   1        synchronous active-high reset
//   ring_sel   in   WIDTH    one-hot digit select
//   digits     in   4*WIDTH  hex nibbles, digit i = digits[4*i+3:4*i]
//   dp_in      in   WIDTH    decimal point per digit
//   an         out  WIDTH    digit enables, active-high, at most one set
//   seg        out  7        segments {g,f,e,d,c,b,a}, active-high
//   dp         out  1        decimal point of the driven digit
//   digit_idx  out  IDX_W    binary index of the driven digit
//   sel_err    out  1        high while in FAULT
//   err_cnt    out  8        (only with SEG7_ERR_CNT_EN) saturating count of FAULT entries
// Build option: define SEG7_ERR_CNT_EN to add the err_cnt output and its counter.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int BLANK_CYC = 2,
    localparam int IDX_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   ring_sel,
    input  logic [4*WIDTH-1:0] digits,
    input  logic [WIDTH-1:0]   dp_in,
    output logic [WIDTH-1:0]   an,
    output logic [6:0]         seg,
    output logic               dp,
    output logic [IDX_W-1:0]   digit_idx,
    output logic               sel_err
`ifdef SEG7_ERR_CNT_EN
    ,
    output logic [7:0]         err_cnt
`endif
);

    localparam int CNT_W = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(BLANK_CYC - 1);

    seg7_state_e       state_q;
    logic [WIDTH-1:0]  sel_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [WIDTH-1:0]  an_q;
    logic [6:0]        seg_q;
    logic              dp_q;
    logic [IDX_W-1:0]  idx_q;
    logic              err_q;

    logic              sel_valid;
    logic              sel_changed;
    logic [IDX_W-1:0]  idx_d;
    logic [3:0]        nib_d;
    logic              dp_d;
    logic [6:0]        seg_d;

    // One-hot test: nonzero with a single bit set.
    assign sel_valid   = (ring_sel != '0) &&
                         ((ring_sel & (ring_sel - WIDTH'(1))) == '0);
    assign sel_changed = (ring_sel != sel_q);

    // Index, nibble and decimal point of the latched select. sel_q is always
    // one-hot whenever it is used to drive, so the loop picks a single digit.
    always_comb begin
        idx_d = '0;
        nib_d = 4'h0;
        dp_d  = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (sel_q[i]) begin
                idx_d = IDX_W'(i);
                nib_d = digits[4*i +: 4];
                dp_d  = dp_in[i];
            end
        end
    end

    hex2seg7 u_hex2seg7 (
        .nibble_i (nib_d),
        .seg_o    (seg_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_BLANK;
            sel_q   <= '0;
            cnt_q   <= CNT_RELOAD;
            an_q    <= '0;
            seg_q   <= SEG_OFF;
            dp_q    <= 1'b0;
            idx_q   <= '0;
            err_q   <= 1'b0;
        end else if (!sel_valid) begin
            // sel_q is deliberately left alone; FAULT exit always reloads it.
            state_q <= ST_FAULT;
            an_q    <= '0;
            seg_q   <= SEG_OFF;
            dp_q    <= 1'b0;
            err_q   <= 1'b1;
        end else begin
            case (state_q)
                ST_FAULT: begin
                    state_q <= ST_BLANK;
                    sel_q   <= ring_sel;
                    cnt_q   <= CNT_RELOAD;
                    err_q   <= 1'b0;
                end
                ST_BLANK: begin
                    an_q  <= '0;
                    seg_q <= SEG_OFF;
                    dp_q  <= 1'b0;
                    if (sel_changed) begin
                        // A new select during blanking restarts the interval.
                        sel_q <= ring_sel;
                        cnt_q <= CNT_RELOAD;
                    end else if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        state_q <= ST_DRIVE;
                        an_q    <= sel_q;
                        idx_q   <= idx_d;
                        seg_q   <= seg_d;
                        dp_q    <= dp_d;
                    end
                end
                ST_DRIVE: begin
                    if (sel_changed) begin
                        state_q <= ST_BLANK;
                        sel_q   <= ring_sel;
                        cnt_q   <= CNT_RELOAD;
                        an_q    <= '0;
                        seg_q   <= SEG_OFF;
                        dp_q    <= 1'b0;
                    end else begin
                        // Re-sample every cycle so digit/dp edits show with no blanking.
                        an_q  <= sel_q;
                        idx_q <= idx_d;
                        seg_q <= seg_d;
                        dp_q  <= dp_d;
                    end
                end
                default: begin
                    state_q <= ST_BLANK;
                    sel_q   <= ring_sel;
                    cnt_q   <= CNT_RELOAD;
                    an_q    <= '0;
                    seg_q   <= SEG_OFF;
                    dp_q    <= 1'b0;
                end
            endcase
        end
    end

    assign an        = an_q;
    assign seg       = seg_q;
    assign dp        = dp_q;
    assign digit_idx = idx_q;
    assign sel_err   = err_q;

`ifdef SEG7_ERR_CNT_EN
    logic [7:0] err_cnt_q;

    // Counts entries into FAULT only: an invalid select while already in FAULT
    // does not count again.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= 8'h00;
        end else if (!sel_valid && (state_q != ST_FAULT) && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'h01;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;

    localparam int W   = 4;
    localparam int BC  = 2;
    localparam int IW  = 2;
    localparam int EW  = W + 7 + 1 + IW + 1 + 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst      = 1'b1;
    logic [W-1:0]    ring_sel = '0;
    logic [4*W-1:0]  digits   = 16'h4321;
    logic [W-1:0]    dp_in    = '0;
    logic [W-1:0]    an;
    logic [6:0]      seg;
    logic            dp;
    logic [IW-1:0]   digit_idx;
    logic            sel_err;
    logic [7:0]      err_cnt_w;

    seg7_scan_driver #(.WIDTH(W), .BLANK_CYC(BC)) dut (
        .clk       (clk),
        .rst       (rst),
        .ring_sel  (ring_sel),
        .digits    (digits),
        .dp_in     (dp_in),
        .an        (an),
        .seg       (seg),
        .dp        (dp),
        .digit_idx (digit_idx),
        .sel_err   (sel_err)
`ifdef SEG7_ERR_CNT_EN
        ,
        .err_cnt   (err_cnt_w)
`endif
    );

`ifndef SEG7_ERR_CNT_EN
    assign err_cnt_w = 8'h00;
`endif

    // ---------------- scoreboard state ----------------
    logic [EW-1:0] exp_q[$];
    int n_cmp   = 0;
    int n_err   = 0;
    int cyc     = 0;
    bit running = 1'b1;

    // ---------------- reference model ----------------
    function automatic logic [6:0] hex_seg(input logic [3:0] h);
        case (h)
            4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
        endcase
    endfunction

    // Last BC+1 sampled edges. A digit is lit at an edge exactly when every
    // one of those samples was out of reset, a legal one-hot word, and equal
    // to the current select.
    logic          h_rst[$];
    logic          h_val[$];
    logic [W-1:0]  h_sel[$];
    logic          prev_fault = 1'b0;
    logic [IW-1:0] last_idx   = '0;
    logic [7:0]    cnt_ref    = 8'h00;

    task automatic model_step();
        logic          valid_now;
        logic          lit;
        logic [W-1:0]  e_an;
        logic [6:0]    e_seg;
        logic          e_dp;
        logic          e_err;
        logic [7:0]    e_cnt;
        int            idx;
        valid_now = ($countones(ring_sel) == 1);
        h_rst.push_back(rst);
        h_val.push_back(valid_now);
        h_sel.push_back(ring_sel);
        if (h_rst.size() > BC + 1) begin
            void'(h_rst.pop_front());
            void'(h_val.pop_front());
            void'(h_sel.pop_front());
        end
        e_an = '0; e_seg = 7'h00; e_dp = 1'b0; e_err = 1'b0;
        if (rst) begin
            prev_fault = 1'b0;
            last_idx   = '0;
            cnt_ref    = 8'h00;
        end else begin
            lit = (h_rst.size() == BC + 1);
            for (int k = 0; k < h_rst.size(); k++)
                if (h_rst[k] || !h_val[k] || h_sel[k] != ring_sel) lit = 1'b0;
            if (!valid_now && !prev_fault && cnt_ref != 8'hFF) cnt_ref++;
            prev_fault = !valid_now;
            e_err = !valid_now;
            if (lit) begin
                idx      = $clog2(ring_sel);
                last_idx = IW'(idx);
                e_an     = ring_sel;
                e_seg    = hex_seg(digits[4*idx +: 4]);
                e_dp     = dp_in[idx];
            end
        end
`ifdef SEG7_ERR_CNT_EN
        e_cnt = cnt_ref;
`else
        e_cnt = 8'h00;
`endif
        exp_q.push_back({e_an, e_seg, e_dp, last_idx, e_err, e_cnt});
    endtask

    always @(posedge clk) begin
        if (running) begin
            cyc++;
            model_step();
        end
    end

    // ---------------- monitor ----------------
    always begin
        logic [EW-1:0] act;
        logic [EW-1:0] e;
        @(posedge clk);
        if (running) begin
            #1;
            act = {an, seg, dp, digit_idx, sel_err, err_cnt_w};
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL no_expected cycle=%0d actual=%h", cyc, act);
            end else begin
                e = exp_q.pop_front();
                if (act !== e)  begin
                    n_err++;
                    $display("FAIL outputs cycle=%0d actual an=%b seg=%h dp=%b idx=%0d err=%b cnt=%0d required an=%b seg=%h dp=%b idx=%0d err=%b cnt=%0d",
                             cyc, act[22:19], act[18:12], act[11], act[10:9], act[8], act[7:0],
                             e[22:19], e[18:12], e[11], e[10:9], e[8], e[7:0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_sel(input logic [W-1:0] s, input int hold);
        ring_sel = s;
        step(hold);
    endtask

    function automatic logic [W-1:0] rand_invalid();
        logic [W-1:0] v;
        v = W'($urandom_range(0, 15));
        while ($countones(v) == 1) v = W'($urandom_range(0, 15));
        return v;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        logic [W-1:0] cur;
        int r;
        // Reset held two cycles with the ring counter also at zero.
        step(2);
        rst = 1'b0;
        step(3);
        // Leave FAULT, then rotate through every digit including the wrap.
        drive_sel(4'b0001, 4);
        drive_sel(4'b0010, 4);
        drive_sel(4'b0100, 4);
        drive_sel(4'b1000, 4);
        drive_sel(4'b0001, 4);
        // Illegal select while driving, then recovery.
        drive_sel(4'b0110, 2);
        drive_sel(4'b0100, 4);
        // Digit/dp edit while driving digit 0.
        drive_sel(4'b0001, 4);
        digits = 16'h432F;
        dp_in  = 4'b0001;
        step(3);
        digits = 16'h4321;
        dp_in  = 4'b0000;
        // Two select changes one cycle apart restart blanking.
        drive_sel(4'b0010, 1);
        drive_sel(4'b0100, 5);
        // Reset in mid-drive and mid-blank.
        rst = 1'b1; step(1); rst = 1'b0;
        drive_sel(4'b1000, 1);
        rst = 1'b1; step(1); rst = 1'b0;
        drive_sel(4'b1000, 4);

        // Randomized scanning with occasional faults, resets and data edits.
        cur = 4'b1000;
        for (int seg_n = 0; seg_n < 120; seg_n++) begin
            r = $urandom_range(0, 99);
            if (r < 70) begin
                cur = {cur[W-2:0], cur[W-1]};
                ring_sel = cur;
            end else if (r < 82) begin
                cur = W'(1) << $urandom_range(0, W - 1);
                ring_sel = cur;
            end else if (r < 94) begin
                ring_sel = rand_invalid();
            end else begin
                rst = 1'b1;
                ring_sel = '0;
            end
            for (int c = 0, h = $urandom_range(1, 6); c < h; c++) begin
                if ($urandom_range(0, 7) == 0) begin
                    digits = 16'($urandom);
                    dp_in  = W'($urandom_range(0, 15));
                end
                step(1);
                rst = 1'b0;
            end
        end

        running = 1'b0;
        step(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
